// File: rtl/serial_adder.sv
// serial_adder: multi-cycle a + b + cin, one DIGIT_W-bit slice per clock,
// least significant slice first, with a start/busy/done handshake.
// The inter-slice carry is registered; partial results build up in a shadow
// register so the visible sum only changes on the completion edge.
module serial_adder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DIGIT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int unsigned N_DIG = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT_W-1:0] w_a_slice;
    logic [DIGIT_W-1:0] w_b_slice;
    logic [DIGIT_W:0]   w_add;
    logic [WIDTH-1:0]   w_shadow_next;

    assign w_last = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE accepts a new start directly for back-to-back use
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Select the operand slices addressed by the slice counter
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int unsigned d = 0; d < N_DIG; d++) begin
            if (r_cnt == CNT_W'(d)) begin
                w_a_slice = r_a[d*DIGIT_W +: DIGIT_W];
                w_b_slice = r_b[d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // One-digit add with carry in and carry out
    assign w_add = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{DIGIT_W{1'b0}}, r_carry};

    // Shadow value with the current slice merged in; on the last slice this is the full result
    always_comb begin
        w_shadow_next = r_shadow;
        for (int unsigned d = 0; d < N_DIG; d++) begin
            if (r_cnt == CNT_W'(d)) begin
                w_shadow_next[d*DIGIT_W +: DIGIT_W] = w_add[DIGIT_W-1:0];
            end
        end
    end

    // Operand latch, slice progression and result commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_shadow <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_shadow <= w_shadow_next;
            r_carry  <= w_add[DIGIT_W];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_shadow_next;
                r_cout <= w_add[DIGIT_W];
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_shadow_next[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign Cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=32, DIGIT_W=8).
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        Cout;
    logic        ovf;

    int n_vec;
    int n_err;
    int n_done;
    int cyc;
    int done_base;

    serial_adder #(
        .WIDTH  (32),
        .DIGIT_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .Cout (Cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge
    task automatic start_op(input logic [31:0] ia, input logic [31:0] ib, input logic icin);
        a     = ia;
        b     = ib;
        cin   = icin;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) until done is high; returns edges waited after acceptance
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cycles++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) cycles = -1;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_done = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        #1;
        step();
        step();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  sum,           32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        rst_n = 1'b1;
        step();

        // Carry rippling through every slice
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("t1_lat",  cyc,           32'd4);
        check("t1_sum",  sum,           32'h0000_0000);
        check("t1_cout", {31'd0, Cout}, 32'd1);
        check("t1_ovf",  {31'd0, ovf},  32'd0);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        step();
        check("t1_pulse", {31'd0, done}, 32'd0);

        // Signed overflow
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        check("t2_sum",  sum,           32'h8000_0000);
        check("t2_cout", {31'd0, Cout}, 32'd0);
        check("t2_ovf",  {31'd0, ovf},  32'd1);
        step();

        // Subtraction 5 - 3
        start_op(32'd5, 32'hFFFF_FFFC, 1'b1);
        wait_done(cyc);
        check("t3_sum",  sum,           32'h0000_0002);
        check("t3_cout", {31'd0, Cout}, 32'd1);
        check("t3_ovf",  {31'd0, ovf},  32'd0);
        step();

        // Subtraction 3 - 5 (borrow)
        start_op(32'd3, 32'hFFFF_FFFA, 1'b1);
        wait_done(cyc);
        check("t4_sum",  sum,           32'hFFFF_FFFE);
        check("t4_cout", {31'd0, Cout}, 32'd0);
        step();

        // Carry out of the low slice of each half, plus cin into bit 0
        start_op(32'h00FF_00FF, 32'h0001_0000, 1'b1);
        wait_done(cyc);
        check("t5_sum",  sum,           32'h0100_0100);
        check("t5_cout", {31'd0, Cout}, 32'd0);
        step();

        // Start ignored while busy; inputs changed mid-operation
        done_base = n_done;
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
        a     = 32'hAAAA_0000;
        b     = 32'h0000_5555;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_hold_sum", sum, 32'h0100_0100);
        check("t6_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("t6_lat",  cyc,           32'd3);
        check("t6_sum",  sum,           32'h0000_0030);
        check("t6_cout", {31'd0, Cout}, 32'd0);
        for (int k = 0; k < 8; k++) step();
        check("t6_ndone", n_done - done_base, 32'd1);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the second busy cycle
        done_base = n_done;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_done", {31'd0, done}, 32'd0);
        check("t7_sum",  sum,           32'd0);
        check("t7_cout", {31'd0, Cout}, 32'd0);
        check("t7_ovf",  {31'd0, ovf},  32'd0);
        for (int k = 0; k < 8; k++) step();
        check("t7_ndone", n_done - done_base, 32'd0);
        check("t7_sum_after", sum, 32'd0);

        // Back-to-back: start held high in the DONE cycle
        done_base = n_done;
        start_op(32'h0000_0011, 32'h0000_0022, 1'b0);
        wait_done(cyc);
        check("t8_sum1", sum, 32'h0000_0033);
        start_op(32'h0000_0100, 32'h0000_0200, 1'b0);
        check("t8_busy", {31'd0, busy}, 32'd1);
        check("t8_done_low", {31'd0, done}, 32'd0);
        check("t8_hold", sum, 32'h0000_0033);
        wait_done(cyc);
        check("t8_lat",  cyc, 32'd4);
        check("t8_sum2", sum, 32'h0000_0300);
        for (int k = 0; k < 4; k++) step();
        check("t8_ndone", n_done - done_base, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle 32-bit adder that processes the operands one DIGIT_W-bit slice per clock, starting from the least significant slice.
- It is the counterpart of the combinational subtract path in the ALU. It computes a + b + cin with a start/done handshake.
- Subtraction is done by the caller: drive b = ~op2 and cin = 1, and the carry out then carries the usual "no borrow" meaning.
- Sits in the execute stage as the low-area ADD/SUB engine. The controller stalls on busy.

Parameters:
- WIDTH, 32, operand width in bits.
- DIGIT_W, 8, bits added per cycle. Must divide WIDTH evenly.
- N_DIG, WIDTH/DIGIT_W (4), derived slice count. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry into bit 0.
- busy  output  1  high while slices are being added.
- done  output  1  single-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, held stable until the next accepted start.
- Cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: operand sign bits equal and sum sign bit differs.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs and internal state go to 0 and the FSM goes to IDLE. Outputs: busy=0, done=0, sum=0, Cout=0, ovf=0. Reset overrides everything, including start and an operation in progress. A partial result is discarded and done is never raised for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and cin into operand registers, clears the slice counter, sets busy=1 and moves to RUN.
  - start=0 leaves the state unchanged.
- RUN (one slice per edge, counter i from 0 to N_DIG-1):
  - sum slice i and the carry register are loaded with a_slice_i + b_slice_i + carry, using a DIGIT_W+1-bit add.
  - The carry for i=0 is the latched cin.
  - At i=N_DIG-1: Cout takes the final carry, ovf is computed from the latched sign bits and the new sum[WIDTH-1], busy drops to 0 and the FSM moves to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - The next edge returns to IDLE. If start=1 in this cycle, that edge instead accepts the new operands and goes straight to RUN (back-to-back operation).
- Latency: start is sampled at edge k. busy is high after edges k through k+N_DIG-1. sum, Cout and ovf update at edge k+N_DIG, and done is high for the cycle that follows. This gives N_DIG+1 edges from acceptance to the end of the done cycle.
- start while busy=1 is ignored with no side effects. Operand inputs may change freely after acceptance because they are latched.
- sum, Cout and ovf hold their last result until the edge that completes the next operation.
  - Intermediate slices write into a shadow register, so the sum output never shows a partially updated value.
  - sum changes only at the completion edge.
- Arithmetic is modulo 2^WIDTH. The carry chain between slices is registered, so the result must exactly equal the full-width combinational sum.
- DIGIT_W=WIDTH is legal: N_DIG=1, and done pulses after the first edge following acceptance.

Test Plan:
- Carry through every slice: a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 busy cycles sum=0x00000000, Cout=1, ovf=0, done high for 1 cycle.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, Cout=0, ovf=1.
- Subtraction convention: a=5, b=0xFFFFFFFC (~3), cin=1 -> sum=0x00000002, Cout=1. Then a=3, b=0xFFFFFFFA (~5), cin=1 -> sum=0xFFFFFFFE, Cout=0.
- Start ignored while busy: accept a=0x10, b=0x20, then pulse start with a=0xAAAA0000, b=0x5555 during RUN -> result sum=0x30, no extra done, and inputs changed mid-operation do not affect the result.
- Reset mid-operation: accept a=0x12345678, b=0x11111111, hold rst_n=0 for 1 cycle at the second busy cycle -> busy=0, done=0, sum=0, Cout=0, ovf=0, and no done pulse follows.
- Back-to-back: start held high in the DONE cycle with a=0x00000100, b=0x00000200 -> busy rises on the next edge, previous sum holds until the new completion, then sum=0x00000300, giving exactly two done pulses in total.
